cpu_bus_responder: RTL and testbench

//  Downstream of the CPU address decoder: takes its one-hot region enables, paces each access
//  (fixed wait states or flash handshake), muxes the read data and returns cpu_mem_ready/cpu_rdata
//  to the CPU. Accesses to unmapped regions, and flash reads that time out, complete with a

---
 rtl/bus_responder_pkg.sv | 31 +++
 rtl/bus_rdata_mux.sv | 47 ++++
 rtl/cpu_bus_responder.sv | 156 +++++++++++++++
 tb/tb_cpu_bus_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared definitions for the CPU bus responder: region indices, FSM encoding
// and the pattern returned on failed accesses.
package bus_responder_pkg;

    localparam int REG_RAM      = 0;
    localparam int REG_VDP      = 1;
    localparam int REG_STATUS   = 2;
    localparam int REG_DSP      = 3;
    localparam int REG_PAD      = 4;
    localparam int REG_COP      = 5;
    localparam int REG_BOOT     = 6;
    localparam int REG_FCTRL    = 7;
    localparam int REG_AUDIO    = 8;
    localparam int REG_FLASH    = 9;
    localparam int REG_UNMAPPED = 10;
    localparam int NUM_REGIONS  = 10;

    localparam logic [31:0] ERROR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Keeps only the lowest set bit; an all-zero result means UNMAPPED.
    function automatic logic [NUM_REGIONS-1:0] lowest_onehot(input logic [NUM_REGIONS-1:0] en);
        return en & (~en + NUM_REGIONS'(1));
    endfunction

endpackage

// File: rtl/bus_rdata_mux.sv
// Combinational read-data selector: one-hot region select to a 32-bit word.
// cop_ram is write-only and contributes zero.
module bus_rdata_mux
    import bus_responder_pkg::*;
(
    input  logic [NUM_REGIONS-1:0] sel,
    input  logic [31:0]            cpu_ram_rdata,
    input  logic [15:0]            vdp_rdata,
    input  logic [31:0]            status_rdata,
    input  logic [31:0]            dsp_rdata,
    input  logic [31:0]            pad_rdata,
    input  logic [31:0]            bootloader_rdata,
    input  logic [31:0]            flash_ctrl_rdata,
    input  logic [31:0]            audio_ctrl_rdata,
    input  logic [31:0]            flash_read_data,
    output logic [31:0]            rdata
);

    logic [31:0] w_src    [NUM_REGIONS];
    logic [31:0] w_masked [NUM_REGIONS];

    assign w_src[REG_RAM]    = cpu_ram_rdata;
    assign w_src[REG_VDP]    = {16'h0000, vdp_rdata};
    assign w_src[REG_STATUS] = status_rdata;
    assign w_src[REG_DSP]    = dsp_rdata;
    assign w_src[REG_PAD]    = pad_rdata;
    assign w_src[REG_COP]    = 32'h0000_0000;
    assign w_src[REG_BOOT]   = bootloader_rdata;
    assign w_src[REG_FCTRL]  = flash_ctrl_rdata;
    assign w_src[REG_AUDIO]  = audio_ctrl_rdata;
    assign w_src[REG_FLASH]  = flash_read_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_mask
            assign w_masked[gi] = {32{sel[gi]}} & w_src[gi];
        end
    endgenerate

    always_comb begin
        rdata = 32'h0000_0000;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            rdata = rdata | w_masked[i];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Paces each CPU access by region (fixed wait states or flash handshake with timeout)
// and returns a one-cycle ready with read data; failed accesses raise a sticky bus_error.
module cpu_bus_responder
    import bus_responder_pkg::*;
#(
    parameter int unsigned RAM_WAIT      = 0,
    parameter int unsigned VDP_WAIT      = 1,
    parameter int unsigned PERIPH_WAIT   = 0,
    parameter int unsigned FLASH_TIMEOUT = 255,
    parameter logic [31:0] ERROR_RDATA   = ERROR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_mem_valid,
    input  logic [3:0]  cpu_wstrb,
    input  logic        cpu_ram_en,
    input  logic        vdp_en,
    input  logic        status_en,
    input  logic        dsp_en,
    input  logic        pad_en,
    input  logic        cop_ram_en,
    input  logic        bootloader_en,
    input  logic        flash_ctrl_en,
    input  logic        audio_ctrl_en,
    input  logic        flash_read_en,
    input  logic [31:0] cpu_ram_rdata,
    input  logic [15:0] vdp_rdata,
    input  logic [31:0] status_rdata,
    input  logic [31:0] dsp_rdata,
    input  logic [31:0] pad_rdata,
    input  logic [31:0] bootloader_rdata,
    input  logic [31:0] flash_ctrl_rdata,
    input  logic [31:0] audio_ctrl_rdata,
    input  logic [31:0] flash_read_data,
    input  logic        flash_read_ready,
    input  logic        bus_error_clear,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_rdata,
    output logic        bus_error
);

    state_t                 r_state;
    logic [NUM_REGIONS-1:0] r_sel;
    logic                   r_is_write;
    logic [7:0]             r_cnt;
    logic                   r_ready;
    logic [31:0]            r_rdata;
    logic                   r_bus_error;

    logic [NUM_REGIONS-1:0] w_en;
    logic [NUM_REGIONS-1:0] w_sel_new;
    logic                   w_is_write;
    logic [7:0]             w_load_cnt;
    logic [31:0]            w_mux_rdata;

    always_comb begin
        w_en = {flash_read_en, audio_ctrl_en, flash_ctrl_en, bootloader_en, cop_ram_en,
                pad_en, dsp_en, status_en, vdp_en, cpu_ram_en};
        w_is_write = |cpu_wstrb;
        w_sel_new  = lowest_onehot(w_en);
        // The flash window is read-only; a write there behaves like a hole in the map.
        if (w_sel_new[REG_FLASH] && w_is_write) begin
            w_sel_new = '0;
        end
        w_load_cnt = 8'd0;
        if (w_sel_new[REG_RAM] || w_sel_new[REG_BOOT]) begin
            w_load_cnt = 8'(RAM_WAIT);
        end else if (w_sel_new[REG_VDP]) begin
            w_load_cnt = 8'(VDP_WAIT);
        end else if (w_sel_new[REG_FLASH]) begin
            w_load_cnt = 8'(FLASH_TIMEOUT);
        end else if (|w_sel_new) begin
            w_load_cnt = 8'(PERIPH_WAIT);
        end
    end

    bus_rdata_mux u_rdata_mux (
        .sel              (r_sel),
        .cpu_ram_rdata    (cpu_ram_rdata),
        .vdp_rdata        (vdp_rdata),
        .status_rdata     (status_rdata),
        .dsp_rdata        (dsp_rdata),
        .pad_rdata        (pad_rdata),
        .bootloader_rdata (bootloader_rdata),
        .flash_ctrl_rdata (flash_ctrl_rdata),
        .audio_ctrl_rdata (audio_ctrl_rdata),
        .flash_read_data  (flash_read_data),
        .rdata            (w_mux_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_is_write  <= 1'b0;
            r_cnt       <= 8'd0;
            r_ready     <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_bus_error <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            // Any set of bus_error below overrides this clear in the same cycle.
            if (bus_error_clear) begin
                r_bus_error <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cpu_mem_valid) begin
                        r_sel      <= w_sel_new;
                        r_is_write <= w_is_write;
                        r_cnt      <= w_load_cnt;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_sel == '0) begin
                        r_rdata     <= r_is_write ? 32'h0000_0000 : ERROR_RDATA;
                        r_bus_error <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_sel[REG_FLASH]) begin
                        if (flash_read_ready) begin
                            r_rdata <= flash_read_data;
                            r_ready <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (r_cnt == 8'd0) begin
                            r_rdata     <= ERROR_RDATA;
                            r_bus_error <= 1'b1;
                            r_ready     <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end else if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_rdata <= r_is_write ? 32'h0000_0000 : w_mux_rdata;
                        r_ready <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_mem_ready = r_ready;
    assign cpu_rdata     = r_rdata;
    assign bus_error     = r_bus_error;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder: directed scenarios plus randomized
// accesses compared against a behavioural latency/data/error model.
module tb_cpu_bus_responder;

    localparam int          RW  = 0;
    localparam int          VW  = 1;
    localparam int          PW  = 2;
    localparam int          FT  = 6;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_mem_valid = 1'b0;
    logic [3:0]  cpu_wstrb = 4'h0;
    logic [9:0]  en = 10'h0;
    logic        flash_read_ready = 1'b0;
    logic        bus_error_clear = 1'b0;
    logic [31:0] rd [10];
    logic        cpu_mem_ready;
    logic [31:0] cpu_rdata;
    logic        bus_error;

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    cpu_bus_responder #(
        .RAM_WAIT      (RW),
        .VDP_WAIT      (VW),
        .PERIPH_WAIT   (PW),
        .FLASH_TIMEOUT (FT),
        .ERROR_RDATA   (ERR)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_mem_valid    (cpu_mem_valid),
        .cpu_wstrb        (cpu_wstrb),
        .cpu_ram_en       (en[0]),
        .vdp_en           (en[1]),
        .status_en        (en[2]),
        .dsp_en           (en[3]),
        .pad_en           (en[4]),
        .cop_ram_en       (en[5]),
        .bootloader_en    (en[6]),
        .flash_ctrl_en    (en[7]),
        .audio_ctrl_en    (en[8]),
        .flash_read_en    (en[9]),
        .cpu_ram_rdata    (rd[0]),
        .vdp_rdata        (rd[1][15:0]),
        .status_rdata     (rd[2]),
        .dsp_rdata        (rd[3]),
        .pad_rdata        (rd[4]),
        .bootloader_rdata (rd[6]),
        .flash_ctrl_rdata (rd[7]),
        .audio_ctrl_rdata (rd[8]),
        .flash_read_data  (rd[9]),
        .flash_read_ready (flash_read_ready),
        .bus_error_clear  (bus_error_clear),
        .cpu_mem_ready    (cpu_mem_ready),
        .cpu_rdata        (cpu_rdata),
        .bus_error        (bus_error)
    );

    // Expected outcome of one access. fk = cycle after accept in which flash ready pulses (0 = never).
    function automatic void model(input logic [9:0] e, input logic [3:0] ws, input int fk,
                                  output int lat, output logic [31:0] data, output logic err);
        int region;
        bit wr;
        region = -1;
        wr = (ws != 4'h0);
        for (int i = 9; i >= 0; i--) begin
            if (e[i]) region = i;
        end
        if (region == 9 && wr) region = -1;
        err = 1'b0;
        if (region < 0) begin
            lat = 2;
            data = wr ? 32'h0 : ERR;
            err = 1'b1;
        end else if (region == 9) begin
            if (fk >= 1 && fk <= FT + 1) begin
                lat = fk + 1;
                data = rd[9];
            end else begin
                lat = FT + 2;
                data = ERR;
                err = 1'b1;
            end
        end else begin
            case (region)
                0, 6:    lat = 2 + RW;
                1:       lat = 2 + VW;
                default: lat = 2 + PW;
            endcase
            if (wr || region == 5) data = 32'h0;
            else if (region == 1)  data = {16'h0, rd[1][15:0]};
            else                   data = rd[region];
        end
    endfunction

    task automatic randomize_rdata();
        for (int i = 0; i < 10; i++) rd[i] = $urandom;
    endtask

    // Runs one access starting in the current cycle; always returns #1 after a posedge.
    task automatic run_access(input string name, input logic [9:0] e, input logic [3:0] ws,
                              input int fk, input bit scramble, input bit clr);
        int          lat;
        logic [31:0] data;
        logic        err;
        int          n;
        int          got;
        model(e, ws, fk, lat, data, err);
        cpu_mem_valid = 1'b1;
        en = e;
        cpu_wstrb = ws;
        bus_error_clear = clr;
        n = 0;
        got = -1;
        while (n < 400 && got < 0) begin
            @(posedge clk);
            #1;
            n++;
            flash_read_ready = (n == fk);
            if (scramble) en = 10'($urandom);
            if (cpu_mem_ready) got = n;
        end
        cpu_mem_valid = 1'b0;
        en = 10'h0;
        cpu_wstrb = 4'h0;
        flash_read_ready = 1'b0;
        bus_error_clear = 1'b0;
        if (err) exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        n_checks++;
        if (got !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, got, lat);
        end
        n_checks++;
        if (cpu_rdata !== data) begin
            n_fail++;
            $display("FAIL %s rdata: got %h, expected %h", name, cpu_rdata, data);
        end
        n_checks++;
        if (bus_error !== exp_err) begin
            n_fail++;
            $display("FAIL %s bus_error: got %b, expected %b", name, bus_error, exp_err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cpu_mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_width: got %b, expected 0", name, cpu_mem_ready);
        end
        $display("access %-14s en=%h ws=%h fk=%0d lat=%0d rdata=%h err=%b",
                 name, e, ws, fk, got, cpu_rdata, bus_error);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_mem_valid = 1'b1;
        en = 10'h001;
        randomize_rdata();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cpu_mem_ready !== 1'b0 || cpu_rdata !== 32'h0 || bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b rdata=%h err=%b, expected 0/0/0",
                     cpu_mem_ready, cpu_rdata, bus_error);
        end
        cpu_mem_valid = 1'b0;
        en = 10'h0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset done ready=%b rdata=%h err=%b", cpu_mem_ready, cpu_rdata, bus_error);
    endtask

    task automatic test_directed();
        randomize_rdata();
        rd[0] = 32'h1234_5678;
        run_access("ram_read", 10'h001, 4'h0, 0, 0, 0);
        run_access("vdp_write", 10'h002, 4'hF, 0, 0, 0);
        rd[1] = 32'h5555_BEEF;
        run_access("vdp_read", 10'h002, 4'h0, 0, 0, 0);
        run_access("flash_k3", 10'h200, 4'h0, 3, 0, 0);
        run_access("flash_cnt0", 10'h200, 4'h0, FT + 1, 0, 0);
        run_access("cop_read", 10'h020, 4'h0, 0, 0, 0);
        run_access("multi_en", 10'h0C4, 4'h0, 0, 0, 0);
        run_access("status_scram", 10'h004, 4'h0, 0, 1, 0);
    endtask

    task automatic test_errors();
        run_access("flash_timeout", 10'h200, 4'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus_error !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_error: got %b, expected 1", bus_error);
        end
        bus_error_clear = 1'b1;
        @(posedge clk);
        #1;
        bus_error_clear = 1'b0;
        exp_err = 1'b0;
        n_checks++;
        if (bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL error_clear: got %b, expected 0", bus_error);
        end
        run_access("unmapped_rd", 10'h000, 4'h0, 0, 0, 0);
        run_access("b2b_ram", 10'h001, 4'h0, 0, 0, 0);
        run_access("flash_write", 10'h200, 4'h3, 2, 0, 0);
        run_access("set_vs_clr", 10'h000, 4'h1, 0, 0, 1);
        run_access("clr_on_read", 10'h100, 4'h0, 0, 0, 1);
    endtask

    task automatic test_reset_mid_access();
        run_access("unmapped_pre", 10'h000, 4'h0, 0, 0, 0);
        cpu_mem_valid = 1'b1;
        en = 10'h200;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        cpu_mem_valid = 1'b0;
        en = 10'h0;
        reset_n = 1'b1;
        exp_err = 1'b0;
        n_checks++;
        if (cpu_mem_ready !== 1'b0 || bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got ready=%b err=%b, expected 0/0", cpu_mem_ready, bus_error);
        end
        for (int i = 0; i < FT + 4; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (cpu_mem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_drop cycle %0d: got ready=%b, expected 0", i, cpu_mem_ready);
            end
        end
        run_access("post_reset", 10'h001, 4'h0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [9:0] e;
        logic [3:0] ws;
        for (int t = 0; t < 40; t++) begin
            randomize_rdata();
            case ($urandom_range(0, 3))
                0:       e = 10'h0;
                1:       e = 10'(1 << $urandom_range(0, 9));
                2:       e = 10'($urandom);
                default: e = 10'h200;
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_access("random", e, ws, $urandom_range(0, FT + 3),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
